vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Raster timing source for the VGA path. It free-runs horizontal and vertical counters on vga_clk and drives the DrawX/DrawY/blank interface that every sprite renderer consumes. It also drives the hs/vs sync pins and emits per-frame pulses for game-logic update timing. Default timing is 640x480@60 on a 25 MHz vga_clk.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CNT_W, 10, counter and DrawX/DrawY width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
vga_clk  input  1  pixel clock
reset  input  1  asynchronous reset, active-high
DrawX  output  CNT_W  current horizontal count, 0..H_TOTAL-1
DrawY  output  CNT_W  current vertical count, 0..V_TOTAL-1
blank  output  1  1 = visible region (renderer drives palette colour); 0 = force black
hs  output  1  horizontal sync, active-low
vs  output  1  vertical sync, active-low
frame_start  output  1  one-cycle pulse on the cycle counters read (0,0)
vblank_start  output  1  one-cycle pulse on the cycle counters read (0,V_VISIBLE)

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Reset is async and active-high; all flops clear immediately when reset asserts, including mid-frame.
- Reset values: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, vblank_start=0.
- Counters: DrawX increments each vga_clk. At H_TOTAL-1 it wraps to 0 and DrawY increments. DrawY wraps to 0 when DrawX=H_TOTAL-1 and DrawY=V_TOTAL-1. No enable; counters never stall.
- All outputs are registered. Each output is decoded from the next-state counter values, so it is coherent with DrawX/DrawY in the same cycle. Zero decode latency relative to the counters.
- blank = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
- hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 default).
- vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 default). vs changes only on the cycle DrawX wraps to 0.
- frame_start = 1 iff the next counter state is (0,0) and the design is not in reset. The (0,0) state held during reset does not pulse; the first pulse follows the first full frame after reset release, 420000 clocks later by default.
- vblank_start = 1 iff the next state is (0,V_VISIBLE). Exactly one pulse per frame.
- Renderers read ROM on the negedge and register RGB on the posedge. Their colour output therefore lags DrawX/DrawY by one vga_clk (see Optional Feature).
- Boundary: at the (H_TOTAL-1, V_TOTAL-1) to (0,0) wrap, blank rises, frame_start pulses, and hs and vs are both 1 in the same cycle.

Optional Feature:
Macro VGA_SYNC_ALIGN_EN.
- Defined: hs, vs and blank pass through one extra register stage and lag DrawX/DrawY by exactly 1 vga_clk, aligned with registered renderer RGB. The extra stage also resets to hs=1, vs=1, blank=1. frame_start and vblank_start are not delayed.
- Undefined: no extra stage; hs, vs and blank are coincident with DrawX/DrawY.

Test Plan:
- Release reset, run 800 clocks -> DrawX sequences 0..799 then 0; DrawY steps 0 to 1 exactly on the wrap; blank=1 for DrawX 0..639, 0 for 640..799.
- Run 2 frames -> hs low for exactly 96 clocks per line starting at DrawX=656; vs low for exactly 1600 clocks starting at (0,490); frame_start pulses once per 420000 clocks; vblank_start pulses at (0,480).
- Check first frame after reset -> no frame_start until counters wrap from (799,524); first pulse at clock 420000.
- Assert reset at (300,200) asynchronously, mid-cycle -> all outputs at reset values before next vga_clk edge; counting restarts from (0,0) on release.
- Build with VGA_SYNC_ALIGN_EN -> blank falls on the cycle after DrawX=640; hs falls on the cycle after DrawX=656; pulses unchanged.
- Override parameters (H_VISIBLE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1) -> 14-clock lines, 7-line frames, hs/vs windows at 10..11 and 5.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing source.
// Drives DrawX/DrawY counters, blank, active-low hs/vs and per-frame pulses.
// Optional macro VGA_SYNC_ALIGN_EN adds one register stage on hs/vs/blank so
// they line up with renderer RGB that is registered one clock after DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CNT_W     = 10
) (
    input  logic             vga_clk,
    input  logic             reset,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             blank,
    output logic             hs,
    output logic             vs,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             blank_d;
    logic             hs_d;
    logic             vs_d;
    logic             frame_d;
    logic             vblank_d;

    // Next counter position: DrawX wraps each line, DrawY advances on the wrap.
    always_comb begin
        x_nxt = DrawX + 1'b1;
        y_nxt = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt = '0;
            if (DrawY == V_LAST) begin
                y_nxt = '0;
            end else begin
                y_nxt = DrawY + 1'b1;
            end
        end
    end

    // Decode outputs from the next position so registered outputs match the counters.
    always_comb begin
        blank_d  = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_d     = !((x_nxt >= H_SYNC_S) && (x_nxt < H_SYNC_E));
        vs_d     = !((y_nxt >= V_SYNC_S) && (y_nxt < V_SYNC_E));
        frame_d  = (x_nxt == '0) && (y_nxt == '0);
        vblank_d = (x_nxt == '0) && (y_nxt == V_VIS);
    end

    // Counter and frame-pulse registers; reset parks at (0,0) without a pulse.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX        <= '0;
            DrawY        <= '0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            DrawX        <= x_nxt;
            DrawY        <= y_nxt;
            frame_start  <= frame_d;
            vblank_start <= vblank_d;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic blank_r;
    logic hs_r;
    logic vs_r;

    // Sync/blank pipeline: first stage is counter-coherent, second lags by one clock.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            blank_r <= 1'b1;
            hs_r    <= 1'b1;
            vs_r    <= 1'b1;
            blank   <= 1'b1;
            hs      <= 1'b1;
            vs      <= 1'b1;
        end else begin
            blank_r <= blank_d;
            hs_r    <= hs_d;
            vs_r    <= vs_d;
            blank   <= blank_r;
            hs      <= hs_r;
            vs      <= vs_r;
        end
    end
`else
    // Sync/blank registers, coincident with DrawX/DrawY.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            blank <= 1'b1;
            hs    <= 1'b1;
            vs    <= 1'b1;
        end else begin
            blank <= blank_d;
            hs    <= hs_d;
            vs    <= vs_d;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Three instances share clock and reset: default timing, default lines with a
// short frame, and a tiny raster. Expected values come from modular arithmetic
// on the number of clocks since reset release.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 vga_clk = ~vga_clk;

    logic [9:0] dx0, dy0, dx1, dy1, dx2, dy2;
    logic       bl0, hs0, vs0, fs0, vb0;
    logic       bl1, hs1, vs1, fs1, vb1;
    logic       bl2, hs2, vs2, fs2, vb2;

    vga_timing_gen u_def (
        .vga_clk(vga_clk), .reset(reset), .DrawX(dx0), .DrawY(dy0),
        .blank(bl0), .hs(hs0), .vs(vs0), .frame_start(fs0), .vblank_start(vb0)
    );

    vga_timing_gen #(
        .V_VISIBLE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
    ) u_mid (
        .vga_clk(vga_clk), .reset(reset), .DrawX(dx1), .DrawY(dy1),
        .blank(bl1), .hs(hs1), .vs(vs1), .frame_start(fs1), .vblank_start(vb1)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .vga_clk(vga_clk), .reset(reset), .DrawX(dx2), .DrawY(dy2),
        .blank(bl2), .hs(hs2), .vs(vs2), .frame_start(fs2), .vblank_start(vb2)
    );

    logic [24:0] act0, act1, act2;
    assign act0 = {dx0, dy0, bl0, hs0, vs0, fs0, vb0};
    assign act1 = {dx1, dy1, bl1, hs1, vs1, fs1, vb1};
    assign act2 = {dx2, dy2, bl2, hs2, vs2, fs2, vb2};

    // Timing per instance: HV, HF, HS, HB, VV, VF, VS, VB
    int cfg [3][8] = '{
        '{640, 16, 96, 48, 480, 10, 2, 33},
        '{640, 16, 96, 48,  20,  3, 2,  5},
        '{  8,  2,  2,  2,   4,  1, 1,  1}
    };

    typedef struct packed {
        int          t;
        logic [24:0] e0;
        logic [24:0] e1;
        logic [24:0] e2;
    } exp_t;

    exp_t q[$];
    int   t      = 0;
    bit   mon_on = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected {DrawX, DrawY, blank, hs, vs, frame_start, vblank_start} after
    // t clocks since reset release (t=0 is the reset state).
    function automatic logic [24:0] model(input int tt, input int k);
        int hv, hf, hsy, hb, vv, vf, vsy, vbk;
        int ht, vt, ft, p, x, y, ts, ps, sx, sy;
        logic b, h, v, f, vbl;
        hv = cfg[k][0]; hf = cfg[k][1]; hsy = cfg[k][2]; hb  = cfg[k][3];
        vv = cfg[k][4]; vf = cfg[k][5]; vsy = cfg[k][6]; vbk = cfg[k][7];
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vbk;
        ft = ht * vt;
        p  = tt % ft;
        x  = p % ht;
        y  = p / ht;
        ts = tt;
`ifdef VGA_SYNC_ALIGN_EN
        if (tt > 0) ts = tt - 1;
`endif
        ps = ts % ft;
        sx = ps % ht;
        sy = ps / ht;
        b   = (sx < hv) && (sy < vv);
        h   = !((sx >= hv + hf) && (sx < hv + hf + hsy));
        v   = !((sy >= vv + vf) && (sy < vv + vf + vsy));
        f   = (tt > 0) && (p == 0);
        vbl = (x == 0) && (y == vv);
        return {10'(x), 10'(y), b, h, v, f, vbl};
    endfunction

    task automatic check(input string name, input int tt,
                         input logic [24:0] act, input logic [24:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: actual DrawX=%0d DrawY=%0d bl/hs/vs/fs/vb=%b, required DrawX=%0d DrawY=%0d bl/hs/vs/fs/vb=%b",
                     name, tt, act[24:15], act[14:5], act[4:0],
                     exp[24:15], exp[14:5], exp[4:0]);
        end
    endtask

    // One clock of stimulus: advance the model, optionally toggle reset
    // asynchronously mid-cycle, and queue the expected outputs.
    task automatic cycle(input bit assert_rst, input bit release_rst);
        exp_t e;
        @(posedge vga_clk);
        if (reset) t = 0;
        else       t = t + 1;
        #2;
        if (assert_rst) begin
            reset = 1'b1;
            t     = 0;
        end else if (release_rst) begin
            reset = 1'b0;
        end
        e.t  = t;
        e.e0 = model(t, 0);
        e.e1 = model(t, 1);
        e.e2 = model(t, 2);
        q.push_back(e);
        mon_on = 1'b1;
    endtask

    // Monitor: every cycle the DUTs present outputs; compare against the queue.
    always @(negedge vga_clk) begin
        if (mon_on) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: actual queue size 0, required an entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("default", e.t, act0, e.e0);
                check("short_frame", e.t, act1, e.e1);
                check("tiny_raster", e.t, act2, e.e2);
            end
        end
    end

    initial begin
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        // Run into the middle of a line/frame, then hit reset asynchronously.
        while (t < 9900) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        // Two full short frames plus margin: frame/vblank pulses and vsync window.
        repeat (48100) cycle(1'b0, 1'b0);
        // Random reset pulses at random points.
        repeat (6) begin
            repeat ($urandom_range(1, 1500)) cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b1);
        end
        repeat (500) cycle(1'b0, 1'b0);
        @(negedge vga_clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
